// File: rtl/timebase_gen_if.sv
// Control/status bundle for timebase_gen: run/clear in, tick enables and square out.
// Latency: n/a (wires only); backpressure: none, consumers sample tick as an enable.
interface timebase_gen_if #(
    parameter int STAGES = 3
);
    logic              run;
    logic              clear;
    logic [STAGES-1:0] tick;
    logic              square;

    modport master (
        output run,
        output clear,
        input  tick,
        input  square
    );

    modport slave (
        input  run,
        input  clear,
        output tick,
        output square
    );
endinterface

// File: rtl/timebase_gen.sv
// Timebase: base-rate tick, cascaded STAGE_DIV sub-rate ticks and a 50%-duty square wave.
// Latency: all outputs registered, 1 cycle after the wrap term; backpressure: none, run=0 freezes phase.
module timebase_gen #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BASE_HZ   = 100,
    parameter int STAGES    = 3,
    parameter int STAGE_DIV = 10
) (
    input  logic          clock,
    input  logic          reset,
    timebase_gen_if.slave tb_if
);
    localparam int BASE_DIV = CLK_HZ / BASE_HZ;
    localparam int HI       = (BASE_DIV + 1) / 2;
    localparam int CW       = (BASE_DIV > 2) ? $clog2(BASE_DIV) : 1;
    localparam int SW       = (STAGE_DIV > 2) ? $clog2(STAGE_DIV) : 1;

    localparam logic [CW-1:0] LAST0 = CW'(BASE_DIV - 1);
    localparam logic [SW-1:0] LASTK = SW'(STAGE_DIV - 1);
    localparam logic [CW:0]   HI_V  = (CW + 1)'(HI);

    if (CLK_HZ % BASE_HZ != 0) begin : g_err_ratio
        $error("timebase_gen: CLK_HZ must be a multiple of BASE_HZ");
    end
    if (BASE_DIV < 2) begin : g_err_base
        $error("timebase_gen: CLK_HZ/BASE_HZ must be at least 2");
    end
    if (STAGE_DIV < 2) begin : g_err_stage_div
        $error("timebase_gen: STAGE_DIV must be at least 2");
    end
    if (STAGES < 1) begin : g_err_stages
        $error("timebase_gen: STAGES must be at least 1");
    end

    logic [CW-1:0]     cnt0_q, cnt0_d;
    logic              square_q, square_d;
    logic [STAGES-1:0] tick_q, tick_d;
    logic [STAGES-1:0] wrap;

    assign wrap[0] = tb_if.run & (cnt0_q == LAST0);

    always_comb begin
        cnt0_d = cnt0_q;
        if (tb_if.clear) begin
            cnt0_d = '0;
        end else if (wrap[0]) begin
            cnt0_d = '0;
        end else if (tb_if.run) begin
            cnt0_d = cnt0_q + 1'b1;
        end
        // Square tracks the post-edge count, so it is high from the first cycle of each period.
        square_d = ({1'b0, cnt0_d} < HI_V);
        tick_d   = tb_if.clear ? '0 : wrap;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt0_q   <= '0;
            square_q <= 1'b1;
            tick_q   <= '0;
        end else begin
            cnt0_q   <= cnt0_d;
            square_q <= square_d;
            tick_q   <= tick_d;
        end
    end

    for (genvar k = 1; k < STAGES; k++) begin : g_stage
        logic [SW-1:0] cnt_q, cnt_d;

        // A stage only moves when every stage below it wraps in the same cycle.
        assign wrap[k] = wrap[k-1] & (cnt_q == LASTK);

        always_comb begin
            cnt_d = cnt_q;
            if (tb_if.clear) begin
                cnt_d = '0;
            end else if (wrap[k]) begin
                cnt_d = '0;
            end else if (wrap[k-1]) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign tb_if.tick   = tick_q;
    assign tb_if.square = square_q;
endmodule
